// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: opcodes, flag bit positions,
// default datapath width and a small opcode-class helper.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_NOR = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

  // Only the adder path produces meaningful carry/overflow; reserved ops fall
  // into the logical class.
  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational {Z,N,C,V} generation from an ALU result and its opcode.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] result_i,
  input  logic [2:0]       op_i,
  input  logic             carry_i,
  input  logic             ovf_i,
  output flags_t           flags_o
);

  logic arith;

  assign arith = op_is_arith(op_i);

  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_Z] = (result_i == '0);
    flags_o[FLAG_N] = result_i[WIDTH-1];
    flags_o[FLAG_C] = arith & carry_i;
    flags_o[FLAG_V] = arith & ovf_i;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: two-entry skid buffer with per-entry flags,
// sticky flag accumulation and a delivered-operation counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  input  logic             clr_sticky,
  output logic [3:0]       sticky_flags,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] head_res_q, head_res_d;
  flags_t           head_flg_q, head_flg_d;
  logic [WIDTH-1:0] tail_res_q, tail_res_d;
  flags_t           tail_flg_q, tail_flg_d;
  flags_t           sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  flags_t new_flags;
  logic   accept;
  logic   deliver;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result_i (in_result),
    .op_i     (in_op),
    .carry_i  (in_carry),
    .ovf_i    (in_ovf),
    .flags_o  (new_flags)
  );

  assign accept  = in_valid && in_ready_q;
  assign deliver = (state_q != ST_EMPTY) && out_ready;

  always_comb begin
    state_d    = state_q;
    head_res_d = head_res_q;
    head_flg_d = head_flg_q;
    tail_res_d = tail_res_q;
    tail_flg_d = tail_flg_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_res_d = in_result;
          head_flg_d = new_flags;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && deliver) begin
          head_res_d = in_result;
          head_flg_d = new_flags;
        end else if (accept) begin
          tail_res_d = in_result;
          tail_flg_d = new_flags;
          state_d    = ST_FULL;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the head can move.
        if (deliver) begin
          head_res_d = tail_res_q;
          head_flg_d = tail_flg_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_FULL);
  end

  always_comb begin
    sticky_d = sticky_q;
    if (accept) begin
      sticky_d = clr_sticky ? new_flags : (sticky_q | new_flags);
    end else if (clr_sticky) begin
      sticky_d = '0;
    end
  end

  assign count_d = deliver ? (count_q + CNT_W'(1)) : count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      head_res_q <= '0;
      head_flg_q <= '0;
      tail_res_q <= '0;
      tail_flg_q <= '0;
      sticky_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_res_q <= head_res_d;
      head_flg_q <= head_flg_d;
      tail_res_q <= tail_res_d;
      tail_flg_q <= tail_flg_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != ST_EMPTY);
  assign out_result   = head_res_q;
  assign out_flags    = head_flg_q;
  assign sticky_flags = sticky_q;
  assign op_count     = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: flag vectors, backpressure ordering,
// streaming, sticky flags, counter wrap and reset while full.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_result;
  logic        in_carry;
  logic        in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        clr_sticky;
  logic [3:0]  sticky_flags;
  logic [15:0] op_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .in_ovf       (in_ovf),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .clr_sticky   (clr_sticky),
    .sticky_flags (sticky_flags),
    .op_count     (op_count)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] res, input logic c, input logic v);
    in_valid  = 1'b1;
    in_op     = op;
    in_result = res;
    in_carry  = c;
    in_ovf    = v;
  endtask

  // Accepts n sequential results with out_ready held high and drains the buffer.
  task automatic stream(input int n, output int delivered, output int data_err,
                        output int ready_low, output logic done);
    int accepted = 0;
    int exp_idx  = 0;
    logic acc, del;
    delivered = 0;
    data_err  = 0;
    ready_low = 0;
    done      = 1'b0;
    out_ready = 1'b1;
    drive(3'd1, 32'h5A00_0000, 1'b0, 1'b0);
    for (int cyc = 0; cyc < n + 20; cyc++) begin
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (in_valid && !in_ready) ready_low++;
      if (del) begin
        if (out_result !== (32'h5A00_0000 + 32'(exp_idx))) data_err++;
        exp_idx++;
        delivered++;
      end
      step();
      if (acc) begin
        accepted++;
        in_result = 32'h5A00_0000 + 32'(accepted);
        if (accepted == n) in_valid = 1'b0;
      end
      if (accepted == n && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [3:0]  exp_sticky;
    logic [31:0] got[$];
    logic [31:0] exp_seq[3];
    int          dl, de, rl;
    logic        dn;
    logic        seen_valid;
    logic        acc, del;

    vecs[0] = '{3'd1, 32'hF0F0_0000, 1'b0, 1'b0, 4'b0100};
    vecs[1] = '{3'd4, 32'h0000_0000, 1'b1, 1'b0, 4'b1010};
    vecs[2] = '{3'd0, 32'h0000_0000, 1'b1, 1'b0, 4'b1000};
    vecs[3] = '{3'd5, 32'h8000_0000, 1'b1, 1'b1, 4'b0111};
    vecs[4] = '{3'd2, 32'h1234_5678, 1'b1, 1'b1, 4'b0000};
    vecs[5] = '{3'd3, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'b0100};
    vecs[6] = '{3'd6, 32'h0000_0000, 1'b1, 1'b1, 4'b1000};
    vecs[7] = '{3'd7, 32'h8000_0001, 1'b1, 1'b1, 4'b0100};
    vecs[8] = '{3'd4, 32'h7FFF_FFFF, 1'b0, 1'b1, 4'b0001};

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_result = '0; in_carry = 1'b0;
    in_ovf = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sticky", 64'(sticky_flags), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    rst = 1'b0;
    step();

    exp_sticky = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].op, vecs[i].res, vecs[i].c, vecs[i].v);
      step();
      exp_sticky = exp_sticky | vecs[i].flags;
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_result", i), 64'(out_result), 64'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 64'(out_flags), 64'(vecs[i].flags));
      check($sformatf("vec%0d_count", i), 64'(op_count), 64'(i));
      check($sformatf("vec%0d_sticky", i), 64'(sticky_flags), 64'(exp_sticky));
    end
    in_valid = 1'b0;
    step();
    check("vec_drain_count", 64'(op_count), 64'd9);
    check("vec_drain_valid", 64'(out_valid), 64'd0);

    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("sticky_clear", 64'(sticky_flags), 64'd0);
    drive(3'd1, 32'h8000_0000, 1'b0, 1'b0);
    step();
    check("sticky_n", 64'(sticky_flags), 64'b0100);
    drive(3'd0, 32'h0000_0000, 1'b0, 1'b0);
    step();
    check("sticky_nz", 64'(sticky_flags), 64'b1100);
    drive(3'd5, 32'h0000_0001, 1'b0, 1'b1);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    in_valid   = 1'b0;
    check("sticky_clr_accept", 64'(sticky_flags), 64'b0001);
    step(); step();

    exp_seq[0] = 32'hAAAA_0001;
    exp_seq[1] = 32'hBBBB_0002;
    exp_seq[2] = 32'hCCCC_0003;
    out_ready = 1'b0;
    drive(3'd1, exp_seq[0], 1'b0, 1'b0);
    step();
    check("bp_ready_after_a", 64'(in_ready), 64'd1);
    drive(3'd1, exp_seq[1], 1'b0, 1'b0);
    step();
    check("bp_ready_after_b", 64'(in_ready), 64'd0);
    drive(3'd1, exp_seq[2], 1'b0, 1'b0);
    step(); step();
    check("bp_hold_ready", 64'(in_ready), 64'd0);
    check("bp_hold_head", 64'(out_result), 64'(exp_seq[0]));
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) got.push_back(out_result);
      step();
      if (acc) in_valid = 1'b0;
      if (!in_valid && !out_valid) break;
    end
    check("bp_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) check($sformatf("bp_order%0d", i), 64'(got[i]), 64'(exp_seq[i]));
      else check($sformatf("bp_order%0d", i), 64'hDEAD, 64'(exp_seq[i]));
    end
    step();
    check("bp_no_extra", 64'(out_valid), 64'd0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    stream(100, dl, de, rl, dn);
    check("stream_done", 64'(dn), 64'd1);
    check("stream_delivered", 64'(dl), 64'd100);
    check("stream_data", 64'(de), 64'd0);
    check("stream_ready_low", 64'(rl), 64'd0);
    check("stream_op_count", 64'(op_count), 64'd100);

    stream(65435, dl, de, rl, dn);
    check("preload_done", 64'(dn), 64'd1);
    check("preload_count", 64'(op_count), 64'hFFFF);
    stream(1, dl, de, rl, dn);
    check("wrap_done", 64'(dn), 64'd1);
    check("wrap_count", 64'(op_count), 64'h0000);

    out_ready = 1'b0;
    drive(3'd4, 32'h1111_1111, 1'b0, 1'b0);
    step();
    drive(3'd4, 32'h2222_2222, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    check("full_ready", 64'(in_ready), 64'd0);
    check("full_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_full_valid", 64'(out_valid), 64'd0);
    check("rst_full_ready", 64'(in_ready), 64'd1);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    seen_valid = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      step();
      if (out_valid) seen_valid = 1'b1;
    end
    check("rst_discard", 64'(seen_valid), 64'd0);
    check("rst_discard_count", 64'(op_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit bitwise/arithmetic units (AND/OR/XOR/NOR/ADD/SUB).
- Captures the selected 32-bit result with valid/ready handshake and derives Z/N/C/V flags.
- Buffers up to two results in a skid buffer so the ALU is never stalled combinationally by the consumer.
- Keeps a sticky flag register and a completed-operation counter for the status path.

Parameters:
- WIDTH, 32, datapath width of result and buffer entries.
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  ALU result present this cycle.
- in_ready  output  1  stage can accept; registered, depends only on buffer occupancy.
- in_op  input  3  opcode: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 SUB, 6-7 reserved.
- in_result  input  WIDTH  result from the selected unit.
- in_carry  input  1  carry/borrow-out from adder path.
- in_ovf  input  1  signed overflow from adder path.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head entry.
- out_result  output  WIDTH  head entry result.
- out_flags  output  4  head entry flags {Z,N,C,V}.
- clr_sticky  input  1  synchronous clear of sticky flags.
- sticky_flags  output  4  OR of the flags of all accepted results since the last clear.
- op_count  output  CNT_W  number of results delivered (out_valid && out_ready).

Behaviour:
- Reset (async assert, sync to clk on release): buffer EMPTY, out_valid=0, out_result=0, out_flags=0, in_ready=1, sticky_flags=0, op_count=0.
- Accept = in_valid && in_ready. Deliver = out_valid && out_ready.
- Flags are computed at accept and stored with the entry:
  - Z = (in_result == 0); N = in_result[WIDTH-1].
  - C = in_carry and V = in_ovf only for op 4/5.
  - For ops 0-3 and 6-7: C = 0, V = 0. Reserved ops are otherwise treated as logical; the result passes through unchanged.
- Buffer FSM: EMPTY, ONE, FULL (2 entries, FIFO order).
  - EMPTY: accept -> ONE.
  - ONE: accept only -> FULL. Deliver only -> EMPTY. Accept and deliver together -> ONE, head replaced by new entry.
  - FULL: deliver -> ONE, second entry becomes head. No accept possible because in_ready = 0.
- in_ready = (state != FULL), registered. Throughput 1 result/cycle while the consumer is ready.
- Latency: a result accepted at edge N is on out_* after edge N and is deliverable at edge N+1.
- out_result/out_flags hold stable while out_valid && !out_ready. in_* are ignored when in_ready = 0.
- sticky_flags:
  - On accept: sticky |= new flags.
  - On clr_sticky alone: sticky = 0.
  - clr_sticky and accept in the same cycle: sticky = new flags only.
- op_count increments on each deliver and wraps from 2^CNT_W-1 to 0 with no saturation or flag.
- Asserting rst mid-transfer discards buffered entries; nothing is delivered afterwards.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_AND..OP_SUB.
  - flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
  - WIDTH default.
- Sub-module alu_flag_gen: combinational {Z,N,C,V} from result/op/carry/ovf; reused by future compare logic.
- Skid buffer, counter and sticky logic stay in alu_result_stage.

Test Plan:
- Reset then OR result 0xF0F0_0000 op=1, out_ready=1 -> next cycle out_valid=1, out_result=0xF0F0_0000, out_flags=4'b0100, op_count becomes 1.
- ADD op=4 with result 0x0000_0000, carry=1, ovf=0 -> out_flags=4'b1010. Same values with op=0 (AND) -> out_flags=4'b1000.
- out_ready=0, drive three back-to-back valid results A, B, C:
  - A and B accepted; in_ready drops after the second accept; C is held.
  - Raise out_ready -> A, B, C delivered in order with no loss or duplication.
- Continuous streaming with out_ready=1 for 100 cycles -> 100 deliveries, in_ready stays 1, op_count = 100.
- Sticky: accept N-flag result, then Z-flag result -> sticky = 4'b1100. clr_sticky together with an accept of V-flag SUB -> sticky = 4'b0001.
- Preload op_count to 0xFFFF by 65535 deliveries, deliver one more -> 0x0000. Assert rst while FULL -> out_valid=0, in_ready=1 immediately.
